// File: rtl/irq_pkg.sv
// Shared constants, FSM state type and helpers for the interrupt request front end.
package irq_pkg;

    localparam int NUM_IRQ = 8;
    localparam int ID_W    = 3;

    localparam logic [NUM_IRQ-1:0] MASK_RST = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        SERVICE
    } irq_state_t;

    function automatic logic [NUM_IRQ-1:0] id_onehot(input logic [ID_W-1:0] id);
        return NUM_IRQ'(1) << id;
    endfunction

endpackage

// File: rtl/irq_edge_detect.sv
// Registered copy of the raw request lines plus per-channel set pulse generation.
module irq_edge_detect
    import irq_pkg::*;
#(
    parameter int EDGE_MODE = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_IRQ-1:0] i_req,
    output logic [NUM_IRQ-1:0] o_set
);

    logic [NUM_IRQ-1:0] r_req_q;
    logic [NUM_IRQ-1:0] w_rise;

    // r_req_q clears on reset so a line held high through reset reads as a fresh edge
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_req_q <= '0;
        end else begin
            r_req_q <= i_req;
        end
    end

    assign w_rise = i_req & ~r_req_q;
    assign o_set  = (EDGE_MODE != 0) ? w_rise : i_req;

endmodule

// File: rtl/irq_request_latch.sv
// Eight-channel pending/mask latch with a present/ack/eoi handshake around an external priority encoder.
module irq_request_latch
    import irq_pkg::*;
#(
    parameter int EDGE_MODE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] req,
    input  logic               mask_wr,
    input  logic [NUM_IRQ-1:0] mask_data,
    output logic [NUM_IRQ-1:0] enc_d,
    input  logic [ID_W-1:0]    enc_y,
    input  logic               enc_valid,
    output logic               irq,
    output logic [ID_W-1:0]    irq_id,
    input  logic               ack,
    input  logic               eoi,
    output logic               busy
);

    logic [NUM_IRQ-1:0] w_set;
    logic [NUM_IRQ-1:0] w_clr;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_mask;
    logic [ID_W-1:0]    r_irq_id;
    irq_state_t         r_state;
    irq_state_t         w_state_nxt;

    irq_edge_detect #(
        .EDGE_MODE (EDGE_MODE)
    ) u_edge (
        .i_clk (clk),
        .i_rst (rst),
        .i_req (req),
        .o_set (w_set)
    );

    // set has priority over clr so an edge landing on the acked channel survives
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_mask    <= MASK_RST;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
            if (mask_wr) begin
                r_mask <= mask_data;
            end
        end
    end

    // Driven from registers only, which keeps the encoder loop free of combinational paths
    assign enc_d = r_pending & r_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_irq_id <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && enc_valid) begin
                r_irq_id <= enc_y;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (enc_valid) w_state_nxt = PRESENT;
            PRESENT: if (ack)       w_state_nxt = SERVICE;
            SERVICE: if (eoi)       w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        irq   = 1'b0;
        busy  = 1'b0;
        w_clr = '0;
        case (r_state)
            PRESENT: begin
                irq = 1'b1;
                if (ack) begin
                    w_clr = id_onehot(r_irq_id);
                end
            end
            SERVICE: busy = 1'b1;
            default: ;
        endcase
    end

    assign irq_id = r_irq_id;

endmodule

// File: tb/tb_irq_request_latch.sv
// Directed bench for irq_request_latch with a behavioural handshake model and an encoder stand-in.
module tb_irq_request_latch;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       mask_wr;
    logic [7:0] mask_data;
    logic [7:0] enc_d;
    logic [2:0] enc_y;
    logic       enc_valid;
    logic       irq;
    logic [2:0] irq_id;
    logic       ack;
    logic       eoi;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    irq_request_latch #(
        .EDGE_MODE (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mask_wr   (mask_wr),
        .mask_data (mask_data),
        .enc_d     (enc_d),
        .enc_y     (enc_y),
        .enc_valid (enc_valid),
        .irq       (irq),
        .irq_id    (irq_id),
        .ack       (ack),
        .eoi       (eoi),
        .busy      (busy)
    );

    // Highest-numbered active channel wins
    function automatic int top_bit(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    always_comb begin
        enc_valid = |enc_d;
        enc_y     = (|enc_d) ? 3'(top_bit(enc_d)) : 3'd0;
    end

    // Model: handshake phase 0 = waiting, 1 = presenting, 2 = being serviced
    logic [7:0] m_pending, m_mask, m_reqq;
    int         m_phase;
    int         m_id;
    bit         m_valid = 1'b0;

    always @(posedge clk) begin
        logic [7:0] s, c, vis;
        if (rst) begin
            m_pending = 8'h00;
            m_mask    = 8'hFF;
            m_reqq    = 8'h00;
            m_phase   = 0;
            m_id      = 0;
            m_valid   = 1'b1;
        end else if (m_valid) begin
            s   = req & ~m_reqq;
            c   = 8'h00;
            vis = m_pending & m_mask;
            if (m_phase == 0) begin
                if (vis != 8'h00) begin
                    m_id    = top_bit(vis);
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (ack) begin
                    c       = 8'(1 << m_id);
                    m_phase = 2;
                end
            end else if (eoi) begin
                m_phase = 0;
            end
            m_pending = (m_pending & ~c) | s;
            if (mask_wr) m_mask = mask_data;
            m_reqq = req;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_enc_d", int'(enc_d), int'(m_pending & m_mask));
            chk("model_irq", int'(irq), (m_phase == 1) ? 1 : 0);
            chk("model_busy", int'(busy), (m_phase == 2) ? 1 : 0);
            chk("model_irq_id", int'(irq_id), m_id);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic do_eoi();
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = 8'h00; mask_wr = 1'b0; mask_data = 8'h00; ack = 1'b0; eoi = 1'b0;
        tick();
        tick();
        chk("rst_enc_d", int'(enc_d), 0);
        chk("rst_irq", int'(irq), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_irq_id", int'(irq_id), 0);
        rst = 1'b0;
        tick();

        // single pulse on channel 2
        req = 8'h04;
        tick();
        req = 8'h00;
        chk("t1_enc_d", int'(enc_d), 8'h04);
        chk("t1_irq_early", int'(irq), 0);
        tick();
        chk("t1_irq", int'(irq), 1);
        chk("t1_id", int'(irq_id), 2);
        do_ack();
        chk("t1_busy", int'(busy), 1);
        chk("t1_irq_svc", int'(irq), 0);
        chk("t1_pend_clr", int'(enc_d), 0);
        do_eoi();
        chk("t1_idle_busy", int'(busy), 0);
        tick();
        chk("t1_irq_stays0", int'(irq), 0);

        // two channels together: 6 then 5
        req = 8'h60;
        tick();
        req = 8'h00;
        tick();
        chk("t2_irq", int'(irq), 1);
        chk("t2_id6", int'(irq_id), 6);
        do_ack();
        do_eoi();
        chk("t2_gap", int'(irq), 0);
        tick();
        chk("t2_reassert", int'(irq), 1);
        chk("t2_id5", int'(irq_id), 5);
        do_ack();
        do_eoi();
        tick();

        // masked channel 0
        mask_wr = 1'b1; mask_data = 8'hFE;
        tick();
        mask_wr = 1'b0;
        req = 8'h01;
        tick();
        req = 8'h00;
        chk("t3_masked_enc_d", int'(enc_d), 0);
        tick();
        tick();
        chk("t3_masked_irq", int'(irq), 0);
        mask_wr = 1'b1; mask_data = 8'hFF;
        tick();
        mask_wr = 1'b0;
        chk("t3_unmask_enc_d", int'(enc_d), 8'h01);
        tick();
        chk("t3_irq", int'(irq), 1);
        chk("t3_id0", int'(irq_id), 0);
        do_ack();
        do_eoi();
        tick();

        // no preemption by channel 7
        req = 8'h02;
        tick();
        req = 8'h00;
        tick();
        chk("t4_id1", int'(irq_id), 1);
        req = 8'h80;
        tick();
        req = 8'h00;
        chk("t4_enc_d", int'(enc_d), 8'h82);
        tick();
        chk("t4_id_frozen", int'(irq_id), 1);
        chk("t4_irq_held", int'(irq), 1);
        do_ack();
        do_eoi();
        tick();
        chk("t4_id7", int'(irq_id), 7);
        do_ack();
        do_eoi();
        tick();

        // set wins over clear on channel 3
        req = 8'h08;
        tick();
        req = 8'h00;
        tick();
        chk("t5_id3", int'(irq_id), 3);
        req = 8'h08; ack = 1'b1;
        tick();
        req = 8'h00; ack = 1'b0;
        chk("t5_busy", int'(busy), 1);
        chk("t5_pend_kept", int'(enc_d), 8'h08);
        do_eoi();
        tick();
        chk("t5_irq_again", int'(irq), 1);
        chk("t5_id3_again", int'(irq_id), 3);
        do_ack();
        do_eoi();
        tick();

        // reset during service with 0x55 pending, mask cleared beforehand
        req = 8'h55;
        tick();
        req = 8'h00;
        tick();
        chk("t6_id6", int'(irq_id), 6);
        req = 8'h55; ack = 1'b1;
        tick();
        req = 8'h00; ack = 1'b0;
        chk("t6_pend55", int'(enc_d), 8'h55);
        chk("t6_busy", int'(busy), 1);
        mask_wr = 1'b1; mask_data = 8'h00;
        tick();
        mask_wr = 1'b0;
        chk("t6_masked_all", int'(enc_d), 0);
        rst = 1'b1; req = 8'h10;
        tick();
        chk("t6_rst_enc_d", int'(enc_d), 0);
        chk("t6_rst_irq", int'(irq), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_id", int'(irq_id), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("t6_held_capture", int'(enc_d), 8'h10);
        tick();
        chk("t6_irq", int'(irq), 1);
        chk("t6_id4", int'(irq_id), 4);
        req = 8'h00;
        do_ack();
        do_eoi();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
